// File: rtl/clk_en_gen.sv
// Multi-channel phase-accumulator clock-enable generator with settle/lock tracking.
// Optional square-wave outputs (outclk_sq) are enabled by defining CLK_EN_GEN_SQUARE_OUT_EN.
module clk_en_gen #(
  parameter int unsigned      NUM_CH      = 2,
  parameter int unsigned      ACC_W       = 24,
  parameter int unsigned      LOCK_CYCLES = 1024,
  parameter logic [ACC_W-1:0] INC_INIT    = {1'b1, {(ACC_W-1){1'b0}}},
  localparam int unsigned     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  output logic [NUM_CH-1:0] outen,
  output logic              locked
`ifdef CLK_EN_GEN_SQUARE_OUT_EN
  ,
  output logic [NUM_CH-1:0] outclk_sq
`endif
);

  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              locked_q, locked_d;
  logic [NUM_CH-1:0] outen_q, outen_d;
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [ACC_W-1:0]  inc_q [NUM_CH];
  logic [ACC_W-1:0]  inc_d [NUM_CH];
  logic [ACC_W:0]    sum   [NUM_CH];
  logic [NUM_CH-1:0] ch_hit;
  logic              accept;
  logic              reconfig;

  // Out-of-range channel indices match no channel, so they are accepted but have no effect.
  always_comb begin
    ch_hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) ch_hit[i] = 1'b1;
    end
  end

  assign cfg_ready = (state_q != IDLE);
  assign accept    = cfg_valid && cfg_ready;
  assign reconfig  = accept && (|ch_hit);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (reconfig) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (reconfig) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  always_comb begin
    outen_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
      inc_d[i] = inc_q[i];
      acc_d[i] = '0;
      if (state_q != IDLE) begin
        acc_d[i]   = sum[i][ACC_W-1:0];
        outen_d[i] = sum[i][ACC_W];
      end
      if (reconfig && ch_hit[i]) begin
        inc_d[i]   = cfg_inc;
        acc_d[i]   = '0;
        outen_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      locked_q <= 1'b0;
      outen_q  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= '0;
        inc_q[i] <= INC_INIT;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
      outen_q  <= outen_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        acc_q[i] <= acc_d[i];
        inc_q[i] <= inc_d[i];
      end
    end
  end

  assign outen  = outen_q;
  assign locked = locked_q;

`ifdef CLK_EN_GEN_SQUARE_OUT_EN
  always_comb begin
    outclk_sq = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      outclk_sq[i] = acc_q[i][ACC_W-1];
    end
  end
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed self-checking bench for clk_en_gen: reset, cadence, reconfiguration, settle restart.
module tb_clk_en_gen;

  logic        refclk = 1'b0;
  logic        rst;
  logic        cfg_valid, cfg_valid2;
  logic        cfg_ch;
  logic [1:0]  cfg_ch2;
  logic [23:0] cfg_inc, cfg_inc2;
  logic        cfg_ready, cfg_ready2;
  logic [1:0]  outen;
  logic [2:0]  outen2;
  logic        locked, locked2;
`ifdef CLK_EN_GEN_SQUARE_OUT_EN
  logic [1:0]  outclk_sq;
  logic [2:0]  outclk_sq2;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 refclk = ~refclk;

  clk_en_gen #(
    .NUM_CH     (2),
    .ACC_W      (24),
    .LOCK_CYCLES(16),
    .INC_INIT   (24'h800000)
  ) dut (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch   (cfg_ch),
    .cfg_inc  (cfg_inc),
    .outen    (outen),
    .locked   (locked)
`ifdef CLK_EN_GEN_SQUARE_OUT_EN
    ,
    .outclk_sq(outclk_sq)
`endif
  );

  // Three channels give a 2-bit index, so cfg_ch=3 is representable and out of range.
  clk_en_gen #(
    .NUM_CH     (3),
    .ACC_W      (24),
    .LOCK_CYCLES(16),
    .INC_INIT   (24'h800000)
  ) dut3 (
    .refclk   (refclk),
    .rst      (rst),
    .cfg_valid(cfg_valid2),
    .cfg_ready(cfg_ready2),
    .cfg_ch   (cfg_ch2),
    .cfg_inc  (cfg_inc2),
    .outen    (outen2),
    .locked   (locked2)
`ifdef CLK_EN_GEN_SQUARE_OUT_EN
    ,
    .outclk_sq(outclk_sq2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_outputs();
    check("rst_outen",   32'(outen),      32'd0);
    check("rst_locked",  32'(locked),     32'd0);
    check("rst_ready",   32'(cfg_ready),  32'd0);
    check("rst_outen3",  32'(outen2),     32'd0);
    check("rst_locked3", 32'(locked2),    32'd0);
    check("rst_ready3",  32'(cfg_ready2), 32'd0);
  endtask

  // Both DUTs start at inc=0x800000: first pulse 3 cycles after release, then every other cycle.
  task automatic release_seq();
    rst = 1'b0;
    cyc = 0;
    for (int n = 1; n <= 17; n++) begin
      tick();
      check("rel_outen",   32'(outen),  (cyc >= 3 && cyc % 2 == 1) ? 32'd3 : 32'd0);
      check("rel_locked",  32'(locked), (cyc == 17) ? 32'd1 : 32'd0);
      check("rel_ready",   32'(cfg_ready), 32'd1);
      check("rel_outen3",  32'(outen2), (cyc >= 3 && cyc % 2 == 1) ? 32'd7 : 32'd0);
      check("rel_locked3", 32'(locked2), (cyc == 17) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_valid2 = 1'b0;
    cfg_ch     = 1'b0;
    cfg_ch2    = 2'd0;
    cfg_inc    = '0;
    cfg_inc2   = '0;
    tick();
    tick();
    check_reset_outputs();

    release_seq();

    // ch1 -> 0x400000 on the 2-channel DUT; out-of-range write on the 3-channel DUT.
    cfg_valid  = 1'b1;
    cfg_ch     = 1'b1;
    cfg_inc    = 24'h400000;
    cfg_valid2 = 1'b1;
    cfg_ch2    = 2'd3;
    cfg_inc2   = 24'h000001;
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 0) begin
        cfg_valid  = 1'b0;
        cfg_valid2 = 1'b0;
      end
      check("w1_outen1",  32'(outen[1]), (k > 0 && k % 4 == 0) ? 32'd1 : 32'd0);
      check("w1_outen0",  32'(outen[0]), (cyc % 2 == 1) ? 32'd1 : 32'd0);
      check("w1_locked",  32'(locked),   (k == 16) ? 32'd1 : 32'd0);
      check("oor_outen3", 32'(outen2),   (cyc % 2 == 1) ? 32'd7 : 32'd0);
      check("oor_locked", 32'(locked2),  32'd1);
    end

    // ch0 -> 0xFFFFFF: one quiet cycle, then a pulse every cycle.
    cfg_valid = 1'b1;
    cfg_ch    = 1'b0;
    cfg_inc   = 24'hFFFFFF;
    for (int k = 0; k <= 4; k++) begin
      tick();
      if (k == 0) cfg_valid = 1'b0;
      check("wff_outen0", 32'(outen[0]), (k >= 2) ? 32'd1 : 32'd0);
      check("wff_outen1", 32'(outen[1]), (cyc % 4 == 2) ? 32'd1 : 32'd0);
      check("wff_locked", 32'(locked),   32'd0);
    end

    // ch0 -> 0 during SETTLE: no pulses, and settle restarts from this accept.
    cfg_valid = 1'b1;
    cfg_inc   = 24'h000000;
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 0) cfg_valid = 1'b0;
      check("w0_outen0", 32'(outen[0]), 32'd0);
      check("w0_outen1", 32'(outen[1]), (cyc % 4 == 2) ? 32'd1 : 32'd0);
      check("w0_locked", 32'(locked),   (k == 16) ? 32'd1 : 32'd0);
    end

    // ch0 -> 0x800000, then rewritten 8 cycles into SETTLE.
    cfg_valid = 1'b1;
    cfg_inc   = 24'h800000;
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 0) cfg_valid = 1'b0;
      check("s1_outen0", 32'(outen[0]), (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
      check("s1_locked", 32'(locked),   32'd0);
    end
    cfg_valid = 1'b1;
    for (int j = 0; j <= 16; j++) begin
      tick();
      if (j == 0) cfg_valid = 1'b0;
      check("s2_outen0", 32'(outen[0]), (j >= 2 && j % 2 == 0) ? 32'd1 : 32'd0);
      check("s2_outen1", 32'(outen[1]), (cyc % 4 == 2) ? 32'd1 : 32'd0);
      check("s2_locked", 32'(locked),   (j == 16) ? 32'd1 : 32'd0);
    end

    // Reset while locked with a request pending: reset wins, increments restored.
    cfg_valid = 1'b1;
    cfg_ch    = 1'b1;
    cfg_inc   = 24'h123456;
    rst       = 1'b1;
    tick();
    check_reset_outputs();
    tick();
    check_reset_outputs();
    cfg_valid = 1'b0;
    release_seq();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
